// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between mantissa alignment (req0)
// and post-add normalization (req1), with a single-entry back-pressured result register.

module barrel_shifter (
  input  logic [31:0] a,
  input  logic [4:0]  shift_amount,
  input  logic        left,
  output logic [31:0] res
);
  logic [31:0] stage;

  // Logarithmic stages: bit i of the amount shifts by 2**i, zero fill either way.
  always_comb begin
    stage = a;
    for (int unsigned i = 0; i < 5; i++) begin
      if (shift_amount[i]) begin
        stage = left ? (stage << (32'd1 << i)) : (stage >> (32'd1 << i));
      end
    end
    res = stage;
  end
endmodule

module shifter_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_amt,
  input  logic             req0_left,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_amt,
  input  logic             req1_left,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
  output logic             rsp_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  logic        ptr;
  logic        grant0;
  logic        grant1;
  logic        can_load;
  logic        accept;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic        sh_left;
  logic [31:0] sh_res;

  // With both valid, ptr picks the winner; a lone valid requester always wins.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !ptr);
    grant1     = req1_valid && (!req0_valid || ptr);
    can_load   = !rsp_valid || rsp_ready;
    req0_ready = grant0 && can_load && !rst;
    req1_ready = grant1 && can_load && !rst;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sh_a       = grant1 ? req1_a    : req0_a;
    sh_amt     = grant1 ? req1_amt  : req0_amt;
    sh_left    = grant1 ? req1_left : req0_left;
  end

  barrel_shifter u_shifter (
    .a            (sh_a),
    .shift_amount (sh_amt),
    .left         (sh_left),
    .res          (sh_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_id     <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      ptr        <= 1'b0;
    end else if (accept) begin
      rsp_res   <= sh_res;
      rsp_id    <= grant1;
      rsp_valid <= 1'b1;
      ptr       <= ~grant1;
      if (grant1) begin
        if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end else begin
        if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed scenarios plus random traffic against a cycle model,
// with a second instance at CNT_W=2 to observe counter saturation.

module tb_shifter_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_left, req1_left, rsp_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_amt, req1_amt;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_res;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
  logic [31:0] s_rsp_res;
  logic [1:0]  s_grant_cnt0, s_grant_cnt1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_res;
  int          m_ptr;
  int unsigned m_cnt0, m_cnt1;
  bit          acc0, acc1;

  always #5 clk = ~clk;

  shifter_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_left(req0_left),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_left(req1_left),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  shifter_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_left(req0_left),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_left(req1_left),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(s_rsp_res), .rsp_id(s_rsp_id),
    .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
  );

  function automatic logic [31:0] shift_ref(logic [31:0] a, logic [4:0] amt, logic left);
    return left ? (a << amt) : (a >> amt);
  endfunction

  function automatic int model_grant();
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready(int idx);
    return !rst && (model_grant() == idx) && (!m_valid || rsp_ready);
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  // Advance one clock and the model in lockstep; inputs must be stable when called.
  task automatic tick();
    int g;
    bit can;
    logic [31:0] r;
    g   = model_grant();
    can = !m_valid || rsp_ready;
    r   = (g == 1) ? shift_ref(req1_a, req1_amt, req1_left) : shift_ref(req0_a, req0_amt, req0_left);
    acc0 = 0;
    acc1 = 0;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_res = '0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (g >= 0 && can) begin
      m_res = r; m_id = (g == 1); m_valid = 1; m_ptr = 1 - g;
      if (g == 0) begin m_cnt0++; acc0 = 1; end
      else begin m_cnt1++; acc1 = 1; end
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_amt = '0; req0_left = 0;
    req1_a = '0; req1_amt = '0; req1_left = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; rsp_ready = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; rsp_ready = 1;
    req0_valid = 1; req1_valid = 1; req0_a = 32'h1; req1_a = 32'h2;
    tick();
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1} !== {1'b0, 1'b0, 32'h0, 16'h0, 16'h0}) begin
      failures++; $display("FAIL reset_state got v=%b id=%b res=%h c0=%0d c1=%0d exp all zero",
                           rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1);
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single_left();
    do_reset();
    req0_valid = 1; req0_a = 32'h0000_00F0; req0_amt = 5'd4; req0_left = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, grant_cnt0} !== {1'b1, 1'b0, 32'h0000_0F00, 16'd1}) begin
      failures++; $display("FAIL single_rsp got v=%b id=%b res=%h c0=%0d exp v=1 id=0 res=00000f00 c0=1",
                           rsp_valid, rsp_id, rsp_res, grant_cnt0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'h8000_0000; req0_amt = 5'd31; req0_left = 0;
    req1_valid = 1; req1_a = 32'h0000_0001; req1_amt = 5'd31; req1_left = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL simul_first_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, req1_ready} !== {1'b1, 1'b0, 32'h0000_0001, 1'b1}) begin
      failures++; $display("FAIL simul_rsp0 got v=%b id=%b res=%h r1=%b exp v=1 id=0 res=00000001 r1=1",
                           rsp_valid, rsp_id, rsp_res, req1_ready);
    end
    tick();
    req1_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1} !== {1'b1, 1'b1, 32'h8000_0000, 16'd1, 16'd1}) begin
      failures++; $display("FAIL simul_rsp1 got v=%b id=%b res=%h c0=%0d c1=%0d exp v=1 id=1 res=80000000 c0=1 c1=1",
                           rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL simul_drain got v=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h1; req0_amt = 5'd1; req0_left = 1;
    tick();
    req0_a = 32'h3; req0_amt = 5'd0;
    req1_valid = 1; req1_a = 32'h5; req1_amt = 5'd1; req1_left = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1} !== {1'b1, 1'b0, 32'h2, 16'd1, 16'd0}) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b id=%b res=%h c0=%0d c1=%0d exp v=1 id=0 res=00000002 c0=1 c1=0",
                             i, rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1);
      end
    end
    rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, grant_cnt1} !== {1'b1, 1'b1, 32'h2, 16'd1}) begin
      failures++; $display("FAIL bp_release_rsp got v=%b id=%b res=%h c1=%0d exp v=1 id=1 res=00000002 c1=1",
                           rsp_valid, rsp_id, rsp_res, grant_cnt1);
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, grant_cnt0} !== {1'b1, 1'b0, 32'h3, 16'd2}) begin
      failures++; $display("FAIL bp_followup got v=%b id=%b res=%h c0=%0d exp v=1 id=0 res=00000003 c0=2",
                           rsp_valid, rsp_id, rsp_res, grant_cnt0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'hDEAD_BEEF; req0_amt = 5'd0;
    for (int i = 0; i < 5; i++) begin
      req0_left = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({s_rsp_res, s_grant_cnt0, rsp_res, grant_cnt0} !==
          {32'hDEAD_BEEF, 2'(sat(i + 1, 3)), 32'hDEAD_BEEF, 16'(i + 1)}) begin
        failures++; $display("FAIL sat[%0d] got res2=%h c0_2=%0d res16=%h c0_16=%0d exp res=deadbeef c0_2=%0d c0_16=%0d",
                             i, s_rsp_res, s_grant_cnt0, rsp_res, grant_cnt0, sat(i + 1, 3), i + 1);
      end
    end
    req0_valid = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h0000_00FF; req0_amt = 5'd8; req0_left = 1;
    tick();
    req1_valid = 1; req1_a = 32'h1234_5678; req1_amt = 5'd4;
    rst = 1;
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
      failures++; $display("FAIL rstmid_pre got v/r0/r1=%b exp=100", {rsp_valid, req0_ready, req1_ready});
    end
    tick();
    rst = 0;
    checks++;
    if ({rsp_valid, rsp_res, grant_cnt0, grant_cnt1} !== {1'b0, 32'h0, 16'd0, 16'd0}) begin
      failures++; $display("FAIL rstmid_state got v=%b res=%h c0=%0d c1=%0d exp all zero",
                           rsp_valid, rsp_res, grant_cnt0, grant_cnt1);
    end
    rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rstmid_prio got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    checks++;
    if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'h0000_FF00}) begin
      failures++; $display("FAIL rstmid_rsp got v=%b id=%b res=%h exp v=1 id=0 res=0000ff00",
                           rsp_valid, rsp_id, rsp_res);
    end
  endtask

  task automatic test_throughput();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_a = $urandom; req0_amt = 5'($urandom); req0_left = 1'($urandom);
    req1_a = $urandom; req1_amt = 5'($urandom); req1_left = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'(i % 2), m_res}) begin
        failures++; $display("FAIL thru[%0d] got v=%b id=%b res=%h exp v=1 id=%0d res=%h",
                             i, rsp_valid, rsp_id, rsp_res, i % 2, m_res);
      end
      if (acc0) begin req0_a = $urandom; req0_amt = 5'($urandom); req0_left = 1'($urandom); end
      if (acc1) begin req1_a = $urandom; req1_amt = 5'($urandom); req1_left = 1'($urandom); end
    end
    idle_inputs();
    checks++;
    if ({grant_cnt0, grant_cnt1} !== {16'd5, 16'd5}) begin
      failures++; $display("FAIL thru_cnt got c0=%0d c1=%0d exp 5 5", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!(req0_valid && !acc0) || rst) begin
        req0_valid = 1'($urandom); req0_a = $urandom; req0_amt = 5'($urandom); req0_left = 1'($urandom);
      end
      if (!(req1_valid && !acc1) || rst) begin
        req1_valid = 1'($urandom); req1_a = $urandom; req1_amt = 5'($urandom); req1_left = 1'($urandom);
      end
      #1;
      checks++;
      if ({req0_ready, req1_ready, s_req0_ready, s_req1_ready} !==
          {exp_ready(0), exp_ready(1), exp_ready(0), exp_ready(1)}) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%b/%b exp=%b%b",
                             i, {req0_ready, req1_ready}, {s_req0_ready, s_req1_ready}, exp_ready(0), exp_ready(1));
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1, s_rsp_valid, s_rsp_id, s_rsp_res, s_grant_cnt0, s_grant_cnt1} !==
          {m_valid, m_id, m_res, 16'(sat(m_cnt0, 65535)), 16'(sat(m_cnt1, 65535)),
           m_valid, m_id, m_res, 2'(sat(m_cnt0, 3)), 2'(sat(m_cnt1, 3))}) begin
        failures++; $display("FAIL rnd_rsp[%0d] got v=%b id=%b res=%h c=%0d,%0d sc=%0d,%0d exp v=%b id=%b res=%h c=%0d,%0d",
                             i, rsp_valid, rsp_id, rsp_res, grant_cnt0, grant_cnt1, s_grant_cnt0, s_grant_cnt1,
                             m_valid, m_id, m_res, m_cnt0, m_cnt1);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    idle_inputs();
    m_valid = 0; m_id = 0; m_res = '0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
    acc0 = 0; acc1 = 0;
    test_reset();
    test_single_left();
    test_simultaneous();
    test_back_pressure();
    test_saturation();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
